// File: rtl/rf_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rf_wr_arbiter
// Description : Two-requester register-file write-port arbiter with a
//               starvation bound for B and a one-entry forwarded write stage.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_wr_arbiter #(
    parameter int STARVE_MAX = 3
) (
    input  logic        arb_clock,
    input  logic        rst_n,
    input  logic        hold,
    input  logic        a_valid,
    input  logic [4:0]  a_addr,
    input  logic [31:0] a_data,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [4:0]  b_addr,
    input  logic [31:0] b_data,
    output logic        b_ready,
    output logic        reg_W,
    output logic [4:0]  rdc,
    output logic [31:0] rd_in_data,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    output logic        rs_fwd_hit,
    output logic        rt_fwd_hit,
    output logic [31:0] fwd_data
);

    localparam logic [3:0] c_starve_max = 4'(STARVE_MAX);

    logic        r_wb_valid;
    logic [4:0]  r_wb_addr;
    logic [31:0] r_wb_data;
    logic [3:0]  r_starve_cnt;

    logic        w_wb_valid_d;
    logic [4:0]  w_wb_addr_d;
    logic [31:0] w_wb_data_d;
    logic [3:0]  w_starve_cnt_d;

    logic        w_grant_a;
    logic        w_grant_b;
    logic        w_a_xfer;
    logic        w_b_xfer;

    // B wins outright when A is idle, or once it has waited the full bound.
    assign w_grant_b = b_valid & (~a_valid | (r_starve_cnt == c_starve_max));
    assign w_grant_a = a_valid & ~w_grant_b;

    assign a_ready  = w_grant_a & ~hold & rst_n;
    assign b_ready  = w_grant_b & ~hold & rst_n;
    assign w_a_xfer = a_valid & a_ready;
    assign w_b_xfer = b_valid & b_ready;

    always_comb begin
        w_wb_valid_d = r_wb_valid;
        w_wb_addr_d  = r_wb_addr;
        w_wb_data_d  = r_wb_data;
        if (!hold) begin
            if (w_b_xfer) begin
                w_wb_valid_d = (b_addr != 5'd0);
                w_wb_addr_d  = b_addr;
                w_wb_data_d  = b_data;
            end else if (w_a_xfer) begin
                w_wb_valid_d = (a_addr != 5'd0);
                w_wb_addr_d  = a_addr;
                w_wb_data_d  = a_data;
            end else begin
                w_wb_valid_d = 1'b0;
            end
        end
    end

    always_comb begin
        w_starve_cnt_d = r_starve_cnt;
        if (!b_valid || w_b_xfer) begin
            w_starve_cnt_d = 4'd0;
        end else if (!hold && (r_starve_cnt < c_starve_max)) begin
            w_starve_cnt_d = r_starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge arb_clock or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_valid   <= 1'b0;
            r_wb_addr    <= 5'd0;
            r_wb_data    <= 32'd0;
            r_starve_cnt <= 4'd0;
        end else begin
            r_wb_valid   <= w_wb_valid_d;
            r_wb_addr    <= w_wb_addr_d;
            r_wb_data    <= w_wb_data_d;
            r_starve_cnt <= w_starve_cnt_d;
        end
    end

    assign reg_W      = r_wb_valid;
    assign rdc        = r_wb_addr;
    assign rd_in_data = r_wb_data;

    assign rs_fwd_hit = r_wb_valid & (rs_addr == r_wb_addr) & (rs_addr != 5'd0);
    assign rt_fwd_hit = r_wb_valid & (rt_addr == r_wb_addr) & (rt_addr != 5'd0);
    assign fwd_data   = r_wb_data;

endmodule
`default_nettype wire

// File: tb/tb_rf_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_wr_arbiter
// Description : Directed scenarios plus constrained-random traffic for
//               rf_wr_arbiter, checked against a rule-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_wr_arbiter;

    localparam int SM = 3;

    logic        arb_clock = 1'b0;
    logic        rst_n, hold;
    logic        a_valid, b_valid;
    logic [4:0]  a_addr, b_addr, rs_addr, rt_addr;
    logic [31:0] a_data, b_data;
    logic        a_ready, b_ready, reg_W, rs_fwd_hit, rt_fwd_hit;
    logic [4:0]  rdc;
    logic [31:0] rd_in_data, fwd_data;

    int errors = 0;
    int checks = 0;

    // Reference model: the pending register-file write and B's waiting time.
    bit          m_valid;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    int          m_wait;
    bit          obs_a_ready, obs_b_ready, exp_a_xfer, exp_b_xfer;

    rf_wr_arbiter #(.STARVE_MAX(SM)) dut (
        .arb_clock (arb_clock),
        .rst_n     (rst_n),
        .hold      (hold),
        .a_valid   (a_valid),
        .a_addr    (a_addr),
        .a_data    (a_data),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_addr    (b_addr),
        .b_data    (b_data),
        .b_ready   (b_ready),
        .reg_W     (reg_W),
        .rdc       (rdc),
        .rd_in_data(rd_in_data),
        .rs_addr   (rs_addr),
        .rt_addr   (rt_addr),
        .rs_fwd_hit(rs_fwd_hit),
        .rt_fwd_hit(rt_fwd_hit),
        .fwd_data  (fwd_data)
    );

    always #5 arb_clock = ~arb_clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_valid = 1'b0;
        m_addr  = '0;
        m_data  = '0;
        m_wait  = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ":reg_W"}, 32'(reg_W), 32'(m_valid));
        chk({tag, ":rdc"}, 32'(rdc), 32'(m_addr));
        chk({tag, ":rd_in_data"}, rd_in_data, m_data);
        chk({tag, ":fwd_data"}, fwd_data, m_data);
        chk({tag, ":rs_hit"}, 32'(rs_fwd_hit), 32'(m_valid && rs_addr == m_addr && rs_addr != 0));
        chk({tag, ":rt_hit"}, 32'(rt_fwd_hit), 32'(m_valid && rt_addr == m_addr && rt_addr != 0));
    endtask

    // One clock cycle: entered at a falling edge with inputs already driven.
    task automatic step(input string tag);
        bit b_turn, a_ok, b_ok;
        #1;
        b_turn = b_valid && (!a_valid || m_wait >= SM);
        a_ok   = a_valid && !b_turn && !hold && rst_n;
        b_ok   = b_turn && !hold && rst_n;
        obs_a_ready = a_ready;
        obs_b_ready = b_ready;
        chk({tag, ":a_ready"}, 32'(a_ready), 32'(a_ok));
        chk({tag, ":b_ready"}, 32'(b_ready), 32'(b_ok));
        exp_a_xfer = a_ok;
        exp_b_xfer = b_ok;
        @(posedge arb_clock);
        if (!rst_n) begin
            model_clear();
        end else begin
            if (!hold) begin
                if (b_ok) begin
                    m_valid = (b_addr != 0); m_addr = b_addr; m_data = b_data;
                end else if (a_ok) begin
                    m_valid = (a_addr != 0); m_addr = a_addr; m_data = a_data;
                end else begin
                    m_valid = 1'b0;
                end
            end
            if (!b_valid || b_ok) m_wait = 0;
            else if (!hold && m_wait < SM) m_wait = m_wait + 1;
        end
        #1;
        check_outputs(tag);
        @(negedge arb_clock);
    endtask

    initial begin
        logic [7:0] b_pattern;
        rst_n = 1'b0; hold = 1'b0;
        a_valid = 1'b1; a_addr = 5'd3; a_data = 32'hDEAD_BEEF;
        b_valid = 1'b1; b_addr = 5'd4; b_data = 32'hCAFE_F00D;
        rs_addr = 5'd3; rt_addr = 5'd4;
        model_clear();

        // Reset state: everything cleared, no readiness while held in reset.
        @(negedge arb_clock);
        #1;
        chk("rst:a_ready", 32'(a_ready), 32'd0);
        chk("rst:b_ready", 32'(b_ready), 32'd0);
        chk("rst:reg_W", 32'(reg_W), 32'd0);
        chk("rst:rd_in_data", rd_in_data, 32'd0);
        @(negedge arb_clock);
        rst_n = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
        @(negedge arb_clock);

        // Single A write to r5.
        a_valid = 1'b1; a_addr = 5'd5; a_data = 32'h1234_5678; rs_addr = 5'd5;
        step("a_only");
        chk("a_only:ready", 32'(obs_a_ready), 32'd1);
        chk("a_only:rdc", 32'(rdc), 32'd5);
        chk("a_only:data", rd_in_data, 32'h1234_5678);
        a_valid = 1'b0;
        step("a_only_idle");
        chk("a_only_idle:reg_W", 32'(reg_W), 32'd0);

        // Contention: B wins every fourth cycle with STARVE_MAX = 3.
        b_pattern = 8'b1000_1000;
        a_valid = 1'b1; b_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a_addr = 5'(10 + i); a_data = 32'hA000_0000 + 32'(i);
            b_addr = 5'(20 + i); b_data = 32'hB000_0000 + 32'(i);
            step("contend");
            chk("contend:b_grant", 32'(obs_b_ready), 32'(b_pattern[i]));
            chk("contend:a_grant", 32'(obs_a_ready), 32'(!b_pattern[i]));
            chk("contend:starve", 32'(dut.r_starve_cnt), 32'(b_pattern[i] ? 0 : (i % 4) + 1));
        end
        a_valid = 1'b0; b_valid = 1'b0;
        step("contend_idle");

        // Write to r0 completes without asserting reg_W.
        a_valid = 1'b1; a_addr = 5'd0; a_data = 32'hFFFF_FFFF;
        step("r0");
        chk("r0:ready", 32'(obs_a_ready), 32'd1);
        chk("r0:reg_W", 32'(reg_W), 32'd0);

        // Write to r7 then hold for two cycles.
        a_addr = 5'd7; a_data = 32'h0000_0777; b_valid = 1'b1; b_addr = 5'd8; b_data = 32'h888;
        step("hold_xfer");
        a_valid = 1'b1; a_addr = 5'd12; hold = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step("hold");
            chk("hold:a_ready", 32'(obs_a_ready), 32'd0);
            chk("hold:b_ready", 32'(obs_b_ready), 32'd0);
            chk("hold:reg_W", 32'(reg_W), 32'd1);
            chk("hold:rdc", 32'(rdc), 32'd7);
            chk("hold:starve", 32'(dut.r_starve_cnt), 32'd1);
        end
        hold = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
        step("hold_release");
        chk("hold_release:reg_W", 32'(reg_W), 32'd0);

        // Forwarding of an in-flight write to r9.
        a_valid = 1'b1; a_addr = 5'd9; a_data = 32'h9999_0009; rs_addr = 5'd9; rt_addr = 5'd9;
        step("fwd");
        a_valid = 1'b0;
        chk("fwd:rs_hit", 32'(rs_fwd_hit), 32'd1);
        chk("fwd:rt_hit", 32'(rt_fwd_hit), 32'd1);
        chk("fwd:data", fwd_data, 32'h9999_0009);
        rs_addr = 5'd0;
        #1;
        chk("fwd:rs0_hit", 32'(rs_fwd_hit), 32'd0);
        chk("fwd:rt_still", 32'(rt_fwd_hit), 32'd1);

        // Mid-cycle reset discards the in-flight write to r11.
        @(negedge arb_clock);
        m_valid = 1'b0;
        a_valid = 1'b1; a_addr = 5'd11; a_data = 32'h1111_0011;
        #1;
        chk("mrst:a_ready", 32'(a_ready), 32'd1);
        @(posedge arb_clock);
        #1;
        chk("mrst:reg_W_before", 32'(reg_W), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        model_clear();
        chk("mrst:reg_W_now", 32'(reg_W), 32'd0);
        chk("mrst:rdc_now", 32'(rdc), 32'd0);
        chk("mrst:a_ready_now", 32'(a_ready), 32'd0);
        @(negedge arb_clock);
        a_addr = 5'd13; a_data = 32'h1313_1313;
        step("in_rst");
        chk("in_rst:reg_W", 32'(reg_W), 32'd0);
        rst_n = 1'b1;
        step("post_rst");
        chk("post_rst:ready", 32'(obs_a_ready), 32'd1);
        chk("post_rst:reg_W", 32'(reg_W), 32'd1);
        chk("post_rst:rdc", 32'(rdc), 32'd13);

        // Constrained-random traffic; requesters keep their payload until transferred.
        for (int n = 0; n < 400; n++) begin
            if (!a_valid || exp_a_xfer) begin
                a_valid = ($urandom_range(0, 3) != 0);
                a_addr  = 5'($urandom_range(0, 31));
                a_data  = $urandom;
            end
            if (!b_valid || exp_b_xfer) begin
                b_valid = ($urandom_range(0, 2) != 0);
                b_addr  = 5'($urandom_range(0, 31));
                b_data  = $urandom;
            end
            hold    = ($urandom_range(0, 4) == 0);
            rs_addr = ($urandom_range(0, 1) != 0) ? m_addr : 5'($urandom_range(0, 31));
            rt_addr = ($urandom_range(0, 2) == 0) ? 5'd0 : m_addr;
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
